// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared constants for the UART transmit feeder (rev 1.0)   |
// +----------------------------------------------------------------------+
package uart_pkg;

   localparam int DATA_W = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE       = 2'b00;
   localparam state_t ST_LAUNCH     = 2'b01;
   localparam state_t ST_WAIT_START = 2'b10;
   localparam state_t ST_WAIT_DONE  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_feeder_if : byte write port + transmitter handshake (rev 1.0)|
// +----------------------------------------------------------------------+
interface uart_tx_feeder_if;
   import uart_pkg::*;

   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] tx_data;
   logic              tx_send;
   logic              tx_ready;

   modport master (
      output wr_data, wr_valid, tx_ready,
      input  wr_ready, tx_data, tx_send
   );

   modport slave (
      input  wr_data, wr_valid, tx_ready,
      output wr_ready, tx_data, tx_send
   );

endinterface
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_byte_fifo : circular byte FIFO with occupancy count (rev 1.0)   |
// +----------------------------------------------------------------------+
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       wdata,
   output logic [DATA_W-1:0]       rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int             PW     = $clog2(DEPTH);
   localparam int             CW     = PW + 1;
   localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   assign full  = (r_count == C_FULL);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign rdata = r_mem[r_rd_ptr];

   // Flush overrides both sides; a full FIFO refuses writes even if popped this cycle.
   assign w_push = push & ~full  & ~flush;
   assign w_pop  = pop  & ~empty & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_feeder : FIFO-buffered launcher for a UART transmitter       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_tx_feeder_if.slave        bus,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   drop_err,
   output logic                   busy
);

   logic [DATA_W-1:0] w_rdata;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_send_d;
   logic              r_sync1;
   logic              r_sync2;
   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_tx_data;
   logic              r_tx_send;
   logic              r_drop_err;
   logic              r_busy;

   uart_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (bus.wr_valid),
      .pop   (w_pop),
      .wdata (bus.wr_data),
      .rdata (w_rdata),
      .count (count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign bus.wr_ready = ~w_full;
   assign bus.tx_data  = r_tx_data;
   assign bus.tx_send  = r_tx_send;
   assign empty        = w_empty;
   assign drop_err     = r_drop_err;
   assign busy         = r_busy;

   // tx_ready comes from the transmitter's own timing domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= bus.tx_ready;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:       if (w_pop)    w_next = ST_LAUNCH;
         ST_LAUNCH:                   w_next = ST_WAIT_START;
         ST_WAIT_START: if (!r_sync2) w_next = ST_WAIT_DONE;
         ST_WAIT_DONE:  if (r_sync2)  w_next = ST_IDLE;
         default:                     w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pop    = (r_state == ST_IDLE) & ~w_empty & r_sync2 & ~flush;
      w_send_d = (r_state == ST_LAUNCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_data  <= '0;
         r_tx_send  <= 1'b0;
         r_busy     <= 1'b0;
         r_drop_err <= 1'b0;
      end else begin
         if (w_pop) r_tx_data <= w_rdata;
         r_tx_send <= w_send_d;
         r_busy    <= (w_next != ST_IDLE);
         if (flush)                        r_drop_err <= 1'b0;
         else if (bus.wr_valid && w_full)  r_drop_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire
